sram_init_arb: RTL and testbench
================================

Name: sram_init_arb

Overview:
- Memory-side stage directly downstream of the AXI-to-SRAM adapter. It owns the single physical SRAM macro port.
- After reset it zero-fills the whole array, then runs a fixed-priority arbiter between two masters:
  - Primary: the AXI adapter's req/we/addr/be/data port. It never stalls.
  - Secondary: a debug/loader port with req/gnt/rvalid.
- The SoC holds the CPU/AXI fabric in reset until init_done_o=1.

Parameters:
ADDR_WIDTH, 48, byte-address width of the primary/secondary ports
DATA_WIDTH, 128, SRAM word width; must be a power of two >= 8
NUM_WORDS, 1024, SRAM depth in words; must be a power of two
INIT_VALUE, '0, DATA_WIDTH-bit pattern written to every word during init

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
reinit_i  in  1  single-cycle pulse; restarts the zero-fill when in RUN
p_req_i  in  1  primary request
p_we_i  in  1  primary write enable
p_addr_i  in  ADDR_WIDTH  primary byte address
p_be_i  in  DATA_WIDTH/8  primary byte enables
p_wdata_i  in  DATA_WIDTH  primary write data
p_rdata_o  out  DATA_WIDTH  primary read data, valid the cycle after a read request
s_req_i  in  1  secondary request
s_gnt_o  out  1  secondary grant; a request is accepted when req&gnt
s_we_i  in  1  secondary write enable
s_addr_i  in  ADDR_WIDTH  secondary byte address
s_be_i  in  DATA_WIDTH/8  secondary byte enables
s_wdata_i  in  DATA_WIDTH  secondary write data
s_rvalid_o  out  1  secondary read data valid
s_rdata_o  out  DATA_WIDTH  secondary read data
init_done_o  out  1  array initialised; arbiter running
p_err_o  out  1  sticky: a primary request arrived while not in RUN
m_req_o  out  1  SRAM chip enable
m_we_o  out  1  SRAM write enable
m_addr_o  out  $clog2(NUM_WORDS)  SRAM word index
m_be_o  out  DATA_WIDTH/8  SRAM byte enables
m_wdata_o  out  DATA_WIDTH  SRAM write data
m_rdata_i  in  DATA_WIDTH  SRAM read data, 1-cycle latency

Behaviour:
- Word index: addr[LOG_NR_BYTES +: IDX_W], where LOG_NR_BYTES = $clog2(DATA_WIDTH/8) and IDX_W = $clog2(NUM_WORDS). Upper address bits are ignored (aliasing); low LOG_NR_BYTES bits are ignored.
- States: INIT, RUN.
  - Reset enters INIT with cnt=0.
  - Reset values: init_done_o=0, p_err_o=0, s_rvalid_o=0, s_gnt_o=0. All other m_* outputs follow INIT-state assignments.
- INIT, every cycle:
  - Drive m_req=1, m_we=1, m_be all-ones, m_addr=cnt, m_wdata=INIT_VALUE.
  - cnt increments by 1.
  - When cnt==NUM_WORDS-1 is written, the next state is RUN.
  - Init takes exactly NUM_WORDS cycles.
  - init_done_o is registered: it goes 1 on the first RUN cycle.
- RUN arbitration:
  - The primary has absolute priority. When p_req_i=1, drive m_* from the p_* inputs in the same cycle (combinational, zero added latency). s_gnt_o=0.
  - Otherwise s_gnt_o=s_req_i, and m_* is driven from the s_* inputs.
  - No request: m_req=0, m_we=0.
- Read return:
  - p_rdata_o = m_rdata_i, always combinational passthrough. It is meaningful only the cycle after a primary read.
  - A registered flag s_rd_q is set on a secondary read (req&gnt&!we).
  - s_rvalid_o = s_rd_q; s_rdata_o = m_rdata_i.
  - A primary access in the cycle after a secondary read does not disturb s_rdata_o, because the SRAM output reflects the prior access.
- p_err_o: sets when p_req_i=1 in any non-RUN cycle; the primary access is dropped. It clears only on rst_i.
- reinit_i:
  - Honoured only in RUN, and only in a cycle with no p_req_i; otherwise it is ignored.
  - It has priority over a same-cycle secondary request (gnt=0).
  - It returns to INIT with cnt=0, and init_done_o drops the next cycle.
  - An outstanding s_rd_q still returns its rvalid on the first INIT cycle.
  - reinit_i is ignored during INIT.
- Async reset mid-init or mid-RUN: everything returns to reset values immediately; init restarts from 0.
- Simultaneous p_req and s_req: the primary wins; the secondary holds its request until granted (standard req/gnt; request fields must stay stable).

Decomposition:
- Shared package: SRAM request struct (req, we, idx, be, wdata), LOG_NR_BYTES computation function, INIT/RUN state enum.
- No sub-module; a single module of about 150-200 lines.

Test Plan:
- Reset with NUM_WORDS=16: m_we=1 at idx 0..15 on 16 consecutive cycles, INIT_VALUE data; init_done_o=1 on cycle 17; secondary reads of idx 0..15 return 0.
- RUN, primary write addr 0x40 (DATA_WIDTH=128 -> idx 4), be 0x000F, data 0xA5..; next-cycle primary read of 0x40 -> p_rdata_o low 4 bytes 0xA5.., rest 0.
- Same-cycle p_req read of idx 2 and s_req write of idx 3 -> m_addr=2, s_gnt_o=0; next cycle (p_req=0) s_gnt_o=1, m_addr=3, m_we=1.
- Secondary read of idx 5 followed by a primary write of idx 5 -> s_rvalid_o=1 one cycle after gnt with the old data; the primary write is unaffected.
- p_req_i asserted during INIT cycle 3 -> no SRAM write from the primary, p_err_o=1 and stays 1 until rst_i.
- reinit_i in RUN after writing 0xFF to idx 7 -> init_done_o=0 next cycle, NUM_WORDS-cycle refill, then a read of idx 7 returns INIT_VALUE; rst_i pulsed mid-refill restarts cnt at 0.

Source files
------------

// File: rtl/sram_init_arb_pkg.sv
// Shared types and helpers for the SRAM init/arbitration stage.
package sram_init_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of byte-offset address bits below the word index.
    function automatic int log_nr_bytes(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/sram_init_arb.sv
// Owns the SRAM macro port: zero-fills the array after reset, then arbitrates
// between a never-stalling primary port and a req/gnt secondary port.
module sram_init_arb
    import sram_init_arb_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 48,
    parameter int                  DATA_WIDTH = 128,
    parameter int                  NUM_WORDS  = 1024,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                 BE_W       = DATA_WIDTH / 8,
    localparam int                 IDX_W      = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reinit_i,
    input  logic                  p_req_i,
    input  logic                  p_we_i,
    input  logic [ADDR_WIDTH-1:0] p_addr_i,
    input  logic [BE_W-1:0]       p_be_i,
    input  logic [DATA_WIDTH-1:0] p_wdata_i,
    output logic [DATA_WIDTH-1:0] p_rdata_o,
    input  logic                  s_req_i,
    output logic                  s_gnt_o,
    input  logic                  s_we_i,
    input  logic [ADDR_WIDTH-1:0] s_addr_i,
    input  logic [BE_W-1:0]       s_be_i,
    input  logic [DATA_WIDTH-1:0] s_wdata_i,
    output logic                  s_rvalid_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic                  init_done_o,
    output logic                  p_err_o,
    output logic                  m_req_o,
    output logic                  m_we_o,
    output logic [IDX_W-1:0]      m_addr_o,
    output logic [BE_W-1:0]       m_be_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    output state_e                dbg_state_o
);

    localparam int               LOG_NR_BYTES = log_nr_bytes(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_WORDS - 1);

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [IDX_W-1:0]      idx;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;
    } sram_req_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             init_done_q;
    logic             p_err_q;
    logic             s_rd_q;
    logic             s_gnt;
    sram_req_t        m_req;

    // Byte-offset bits and aliased upper bits of the addresses are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p_addr_i, s_addr_i};

    always_comb begin
        m_req   = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        s_gnt   = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                m_req.req   = 1'b1;
                m_req.we    = 1'b1;
                m_req.idx   = cnt_q;
                m_req.be    = '1;
                m_req.wdata = INIT_VALUE;
                cnt_d       = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Primary first, then a refill request, then the secondary.
                if (p_req_i) begin
                    m_req.req   = 1'b1;
                    m_req.we    = p_we_i;
                    m_req.idx   = p_addr_i[LOG_NR_BYTES +: IDX_W];
                    m_req.be    = p_be_i;
                    m_req.wdata = p_wdata_i;
                end else if (reinit_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (s_req_i) begin
                    s_gnt       = 1'b1;
                    m_req.req   = 1'b1;
                    m_req.we    = s_we_i;
                    m_req.idx   = s_addr_i[LOG_NR_BYTES +: IDX_W];
                    m_req.be    = s_be_i;
                    m_req.wdata = s_wdata_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            p_err_q     <= 1'b0;
            s_rd_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == ST_RUN);
            p_err_q     <= p_err_q | (p_req_i & (state_q != ST_RUN));
            s_rd_q      <= s_gnt & s_req_i & ~s_we_i;
        end
    end

    assign m_req_o     = m_req.req;
    assign m_we_o      = m_req.we;
    assign m_addr_o    = m_req.idx;
    assign m_be_o      = m_req.be;
    assign m_wdata_o   = m_req.wdata;
    assign s_gnt_o     = s_gnt;
    assign p_rdata_o   = m_rdata_i;
    assign s_rdata_o   = m_rdata_i;
    assign s_rvalid_o  = s_rd_q;
    assign init_done_o = init_done_q;
    assign p_err_o     = p_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_init_arb.sv
// Directed bench for sram_init_arb with a small 16-word SRAM model.
module tb_sram_init_arb;
    import sram_init_arb_pkg::*;

    localparam int AW = 48;
    localparam int DW = 128;
    localparam int NW = 16;
    localparam int BW = DW / 8;
    localparam int IW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          reinit_i;
    logic          p_req_i, p_we_i;
    logic [AW-1:0] p_addr_i;
    logic [BW-1:0] p_be_i;
    logic [DW-1:0] p_wdata_i, p_rdata_o;
    logic          s_req_i, s_gnt_o, s_we_i;
    logic [AW-1:0] s_addr_i;
    logic [BW-1:0] s_be_i;
    logic [DW-1:0] s_wdata_i, s_rdata_o;
    logic          s_rvalid_o, init_done_o, p_err_o;
    logic          m_req_o, m_we_o;
    logic [IW-1:0] m_addr_o;
    logic [BW-1:0] m_be_o;
    logic [DW-1:0] m_wdata_o, m_rdata_i;
    state_e        dbg_state_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    sram_init_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .INIT_VALUE('0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .reinit_i(reinit_i),
        .p_req_i(p_req_i), .p_we_i(p_we_i), .p_addr_i(p_addr_i), .p_be_i(p_be_i),
        .p_wdata_i(p_wdata_i), .p_rdata_o(p_rdata_o),
        .s_req_i(s_req_i), .s_gnt_o(s_gnt_o), .s_we_i(s_we_i), .s_addr_i(s_addr_i),
        .s_be_i(s_be_i), .s_wdata_i(s_wdata_i), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
        .init_done_o(init_done_o), .p_err_o(p_err_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_be_o(m_be_o),
        .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .dbg_state_o(dbg_state_o)
    );

    // SRAM macro model: byte-enabled write, 1-cycle read latency.
    logic [DW-1:0] mem [NW];
    always @(posedge clk_i) begin
        if (m_req_o) begin
            if (m_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (m_be_o[b]) mem[m_addr_o][b*8 +: 8] <= m_wdata_o[b*8 +: 8];
            end else begin
                m_rdata_i <= mem[m_addr_o];
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        reinit_i = 0; p_req_i = 0; p_we_i = 0; p_addr_i = '0; p_be_i = '0; p_wdata_i = '0;
        s_req_i = 0; s_we_i = 0; s_addr_i = '0; s_be_i = '0; s_wdata_i = '0;
    endtask

    // Entered one step after reset release or a reinit edge; covers a full fill.
    task automatic run_init_sweep();
        for (int i = 0; i < NW; i++) begin
            #1;
            vec_cnt++; if ({m_req_o, m_we_o} !== 2'b11) begin err_cnt++; $display("FAIL sweep_req[%0d]: got %b want 11", i, {m_req_o, m_we_o}); end
            vec_cnt++; if (m_addr_o !== IW'(i)) begin err_cnt++; $display("FAIL sweep_addr[%0d]: got %0d want %0d", i, m_addr_o, i); end
            vec_cnt++; if (m_be_o !== '1 || m_wdata_o !== '0) begin err_cnt++; $display("FAIL sweep_data[%0d]: be %h data %h want ffff/0", i, m_be_o, m_wdata_o); end
            vec_cnt++; if (init_done_o !== 1'b0) begin err_cnt++; $display("FAIL sweep_done[%0d]: got %b want 0", i, init_done_o); end
            step();
        end
        vec_cnt++; if (init_done_o !== 1'b1 || dbg_state_o !== ST_RUN) begin err_cnt++; $display("FAIL sweep_end: done %b state %0d want 1/RUN", init_done_o, dbg_state_o); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        vec_cnt++; if (init_done_o !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b want 0", init_done_o); end
        vec_cnt++; if (p_err_o !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b want 0", p_err_o); end
        vec_cnt++; if (s_rvalid_o !== 1'b0 || s_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL rst_sec: rvalid %b gnt %b want 0/0", s_rvalid_o, s_gnt_o); end
        vec_cnt++; if (dbg_state_o !== ST_INIT || m_addr_o !== '0) begin err_cnt++; $display("FAIL rst_state: state %0d addr %0d want INIT/0", dbg_state_o, m_addr_o); end
        rst_i = 0;
        run_init_sweep();
    endtask

    task automatic test_secondary_zero_reads();
        for (int i = 0; i < NW; i++) begin
            s_req_i = 1; s_we_i = 0; s_addr_i = AW'(i * 16);
            #1;
            vec_cnt++; if (s_gnt_o !== 1'b1 || m_addr_o !== IW'(i) || m_we_o !== 1'b0) begin err_cnt++; $display("FAIL zrd_gnt[%0d]: gnt %b addr %0d we %b want 1/%0d/0", i, s_gnt_o, m_addr_o, m_we_o, i); end
            step();
            s_req_i = 0;
            vec_cnt++; if (s_rvalid_o !== 1'b1 || s_rdata_o !== '0) begin err_cnt++; $display("FAIL zrd_data[%0d]: rvalid %b data %h want 1/0", i, s_rvalid_o, s_rdata_o); end
        end
        step();
        vec_cnt++; if (s_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL zrd_idle: rvalid %b want 0", s_rvalid_o); end
    endtask

    task automatic test_primary_rw();
        logic [DW-1:0] exp_rd;
        exp_rd = {96'h0, 32'hA5A5_A5A5};
        p_req_i = 1; p_we_i = 1; p_addr_i = 48'h40; p_be_i = 16'h000F; p_wdata_i = {16{8'hA5}};
        #1;
        vec_cnt++; if ({m_req_o, m_we_o} !== 2'b11 || m_addr_o !== 4'd4 || m_be_o !== 16'h000F) begin err_cnt++; $display("FAIL pwr_drive: req/we %b addr %0d be %h want 11/4/000f", {m_req_o, m_we_o}, m_addr_o, m_be_o); end
        vec_cnt++; if (m_wdata_o !== {16{8'hA5}} || s_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL pwr_data: data %h gnt %b", m_wdata_o, s_gnt_o); end
        step();
        // Upper bits and byte offset must be ignored: this aliases to idx 4.
        p_we_i = 0; p_addr_i = 48'hF000_0000_004F;
        #1;
        vec_cnt++; if (m_addr_o !== 4'd4 || m_we_o !== 1'b0) begin err_cnt++; $display("FAIL prd_alias: addr %0d we %b want 4/0", m_addr_o, m_we_o); end
        step();
        p_req_i = 0;
        vec_cnt++; if (p_rdata_o !== exp_rd) begin err_cnt++; $display("FAIL prd_data: got %h want %h", p_rdata_o, exp_rd); end
    endtask

    task automatic test_contention();
        p_req_i = 1; p_we_i = 0; p_addr_i = 48'h20;
        s_req_i = 1; s_we_i = 1; s_addr_i = 48'h30; s_be_i = '1; s_wdata_i = 128'h1234;
        #1;
        vec_cnt++; if (m_addr_o !== 4'd2 || m_we_o !== 1'b0 || s_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL cont_pri: addr %0d we %b gnt %b want 2/0/0", m_addr_o, m_we_o, s_gnt_o); end
        step();
        p_req_i = 0;
        vec_cnt++; if (p_rdata_o !== '0) begin err_cnt++; $display("FAIL cont_prd: got %h want 0", p_rdata_o); end
        #1;
        vec_cnt++; if (s_gnt_o !== 1'b1 || m_addr_o !== 4'd3 || m_we_o !== 1'b1 || m_wdata_o !== 128'h1234) begin err_cnt++; $display("FAIL cont_sec: gnt %b addr %0d we %b data %h want 1/3/1/1234", s_gnt_o, m_addr_o, m_we_o, m_wdata_o); end
        step();
        s_req_i = 0; s_we_i = 0;
        vec_cnt++; if (s_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL cont_norv: rvalid %b want 0", s_rvalid_o); end
        p_req_i = 1; p_addr_i = 48'h30;
        step();
        p_req_i = 0;
        vec_cnt++; if (p_rdata_o !== 128'h1234) begin err_cnt++; $display("FAIL cont_chk: got %h want 1234", p_rdata_o); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] old_d, new_d;
        old_d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        new_d = 128'hCAFE_BABE_0000_1111_2222_3333_4444_5555;
        p_req_i = 1; p_we_i = 1; p_addr_i = 48'h50; p_be_i = '1; p_wdata_i = old_d;
        step();
        p_req_i = 0; p_we_i = 0;
        s_req_i = 1; s_we_i = 0; s_addr_i = 48'h50;
        #1;
        vec_cnt++; if (s_gnt_o !== 1'b1 || m_addr_o !== 4'd5) begin err_cnt++; $display("FAIL b2b_gnt: gnt %b addr %0d want 1/5", s_gnt_o, m_addr_o); end
        step();
        s_req_i = 0;
        p_req_i = 1; p_we_i = 1; p_addr_i = 48'h50; p_be_i = '1; p_wdata_i = new_d;
        #1;
        vec_cnt++; if (s_rvalid_o !== 1'b1 || s_rdata_o !== old_d) begin err_cnt++; $display("FAIL b2b_srd: rvalid %b data %h want 1/%h", s_rvalid_o, s_rdata_o, old_d); end
        vec_cnt++; if (m_addr_o !== 4'd5 || m_we_o !== 1'b1 || m_wdata_o !== new_d) begin err_cnt++; $display("FAIL b2b_pwr: addr %0d we %b data %h", m_addr_o, m_we_o, m_wdata_o); end
        step();
        p_we_i = 0;
        vec_cnt++; if (s_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_rvdrop: rvalid %b want 0", s_rvalid_o); end
        step();
        p_req_i = 0;
        vec_cnt++; if (p_rdata_o !== new_d) begin err_cnt++; $display("FAIL b2b_new: got %h want %h", p_rdata_o, new_d); end
    endtask

    task automatic test_reinit();
        p_req_i = 1; p_we_i = 1; p_addr_i = 48'h70; p_be_i = '1; p_wdata_i = 128'hFF;
        step();
        // Refill request is ignored while the primary is active.
        p_we_i = 0; reinit_i = 1;
        step();
        p_req_i = 0; reinit_i = 0;
        vec_cnt++; if (init_done_o !== 1'b1 || dbg_state_o !== ST_RUN || p_rdata_o !== 128'hFF) begin err_cnt++; $display("FAIL reinit_blocked: done %b state %0d rd %h want 1/RUN/ff", init_done_o, dbg_state_o, p_rdata_o); end
        reinit_i = 1; s_req_i = 1; s_we_i = 1; s_addr_i = 48'h80; s_be_i = '1; s_wdata_i = 128'h5;
        #1;
        vec_cnt++; if (s_gnt_o !== 1'b0 || m_req_o !== 1'b0) begin err_cnt++; $display("FAIL reinit_prio: gnt %b req %b want 0/0", s_gnt_o, m_req_o); end
        step();
        reinit_i = 0; s_req_i = 0; s_we_i = 0;
        vec_cnt++; if (init_done_o !== 1'b0 || dbg_state_o !== ST_INIT) begin err_cnt++; $display("FAIL reinit_enter: done %b state %0d want 0/INIT", init_done_o, dbg_state_o); end
        for (int i = 0; i < NW; i++) begin
            if (i == 3) begin p_req_i = 1; p_we_i = 1; p_addr_i = 48'h90; p_be_i = '1; p_wdata_i = '1; end
            if (i == 8) reinit_i = 1;
            #1;
            vec_cnt++; if (m_addr_o !== IW'(i) || m_wdata_o !== '0 || init_done_o !== 1'b0) begin err_cnt++; $display("FAIL refill[%0d]: addr %0d data %h done %b", i, m_addr_o, m_wdata_o, init_done_o); end
            step();
            p_req_i = 0; p_we_i = 0; reinit_i = 0;
            if (i == 3) begin
                vec_cnt++; if (p_err_o !== 1'b1) begin err_cnt++; $display("FAIL perr_set: got %b want 1", p_err_o); end
            end
        end
        vec_cnt++; if (init_done_o !== 1'b1) begin err_cnt++; $display("FAIL refill_done: got %b want 1", init_done_o); end
        for (int k = 0; k < 2; k++) begin
            s_req_i = 1; s_we_i = 0; s_addr_i = (k == 0) ? 48'h70 : 48'h90;
            step();
            s_req_i = 0;
            vec_cnt++; if (s_rvalid_o !== 1'b1 || s_rdata_o !== '0) begin err_cnt++; $display("FAIL refill_rd[%0d]: rvalid %b data %h want 1/0", k, s_rvalid_o, s_rdata_o); end
        end
        vec_cnt++; if (p_err_o !== 1'b1) begin err_cnt++; $display("FAIL perr_sticky: got %b want 1", p_err_o); end
    endtask

    task automatic test_reset_mid_refill();
        reinit_i = 1;
        step();
        reinit_i = 0;
        repeat (5) step();
        vec_cnt++; if (m_addr_o !== 4'd5) begin err_cnt++; $display("FAIL midfill_cnt: got %0d want 5", m_addr_o); end
        #1 rst_i = 1;
        #1;
        vec_cnt++; if (p_err_o !== 1'b0 || init_done_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_flags: err %b done %b want 0/0", p_err_o, init_done_o); end
        vec_cnt++; if (m_addr_o !== '0 || dbg_state_o !== ST_INIT) begin err_cnt++; $display("FAIL midrst_cnt: addr %0d state %0d want 0/INIT", m_addr_o, dbg_state_o); end
        step();
        rst_i = 0;
        run_init_sweep();
    endtask

    initial begin
        test_reset();
        test_secondary_zero_reads();
        test_primary_rw();
        test_contention();
        test_back_to_back();
        test_reinit();
        test_reset_mid_refill();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
